// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle control unit FSM
//   FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH, plus HALT.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_rdata, imem_ready   instruction fetch data / handshake
//   dmem_ready               data memory access complete
//   n, z, p                  condition flags for BR
//   resume                   leave HALT
//   imem_req, ir             fetch request, latched instruction
//   pc_we, pc_sel            PC strobe, 0 = PC+1, 1 = target
//   alu_op, alu_src2_sel, ext_sel, wd_sel, reg_we   datapath control
//   dmem_req, dmem_we, push_ctrl, pop_ctrl, sp_we  memory / stack control
//   halted, state            HALT indicator and debug state
// Opcodes: 0-8 ALU (6 = MUL), 9 LDR, A STR, B PUSH, C POP, D BR, E JMP, F HALT.
module mc_control_unit #(
  parameter int INST_W     = 16,
  parameter int ALUOP_W    = 4,
  parameter int MUL_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INST_W-1:0]  imem_rdata,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  input  logic               n,
  input  logic               z,
  input  logic               p,
  input  logic               resume,
  output logic               imem_req,
  output logic [INST_W-1:0]  ir,
  output logic               pc_we,
  output logic               pc_sel,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               alu_src2_sel,
  output logic               ext_sel,
  output logic               wd_sel,
  output logic               reg_we,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic               push_ctrl,
  output logic               pop_ctrl,
  output logic               sp_we,
  output logic               halted,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_MUL  = 4'h6;
  localparam logic [3:0] OP_LDR  = 4'h9;
  localparam logic [3:0] OP_STR  = 4'hA;
  localparam logic [3:0] OP_PUSH = 4'hB;
  localparam logic [3:0] OP_POP  = 4'hC;
  localparam logic [3:0] OP_BR   = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t            state_reg;
  logic [INST_W-1:0] ir_reg;
  logic [3:0]        mul_cnt_reg;

  logic [3:0]         opcode;
  logic               br_taken;
  logic               mul_done;
  logic               is_mem_op;
  logic               active;
  logic [ALUOP_W-1:0] alu_code;

  assign opcode    = ir_reg[INST_W-1 -: 4];
  assign br_taken  = (n & ir_reg[INST_W-5]) | (z & ir_reg[INST_W-6]) | (p & ir_reg[INST_W-7]);
  assign mul_done  = (mul_cnt_reg == 4'(MUL_CYCLES - 1));
  assign is_mem_op = (opcode >= OP_LDR) && (opcode <= OP_POP);
  assign active    = (state_reg == S_EXEC) || (state_reg == S_MEM) || (state_reg == S_WB);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_FETCH;
      ir_reg      <= '0;
      mul_cnt_reg <= '0;
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (imem_ready) begin
            ir_reg    <= imem_rdata;
            state_reg <= S_DECODE;
          end
        end
        S_DECODE: state_reg <= (opcode == OP_HALT) ? S_HALT : S_EXEC;
        S_EXEC: begin
          if (opcode == OP_MUL) begin
            // MUL sits in EXEC until the counter has seen MUL_CYCLES cycles
            if (mul_done) begin
              mul_cnt_reg <= '0;
              state_reg   <= S_WB;
            end else begin
              mul_cnt_reg <= mul_cnt_reg + 4'd1;
            end
          end else if ((opcode == OP_BR) || (opcode == OP_JMP)) begin
            state_reg <= S_FETCH;
          end else if (is_mem_op) begin
            state_reg <= S_MEM;
          end else begin
            state_reg <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            state_reg <= ((opcode == OP_LDR) || (opcode == OP_POP)) ? S_WB : S_FETCH;
          end
        end
        S_WB:   state_reg <= S_FETCH;
        S_HALT: if (resume) state_reg <= S_FETCH;
        default: state_reg <= S_FETCH;
      endcase
    end
  end

  // ALU code table: ALU opcodes pass through, memory/control ops use fixed codes
  always_comb begin
    alu_code = '0;
    case (opcode)
      4'h9:                alu_code = '0;
      4'hA, 4'hD, 4'hF:    alu_code = ALUOP_W'(4'b1111);
      4'hB:                alu_code = ALUOP_W'(4'b1011);
      4'hC:                alu_code = ALUOP_W'(4'b1100);
      4'hE:                alu_code = ALUOP_W'(4'b0010);
      default:             alu_code = ALUOP_W'(opcode);
    endcase
  end

  // Strobes are Moore decodes of state+ir, qualified by the handshake inputs
  // only where a transfer happens in that very cycle.
  always_comb begin
    imem_req = 1'b0;
    pc_we    = 1'b0;
    pc_sel   = 1'b0;
    reg_we   = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    sp_we    = 1'b0;
    case (state_reg)
      S_FETCH: begin
        // masked while rst is held so nothing is requested before release
        imem_req = ~rst;
        pc_we    = imem_ready & ~rst;
      end
      S_EXEC: begin
        if ((opcode == OP_JMP) || ((opcode == OP_BR) && br_taken)) begin
          pc_we  = 1'b1;
          pc_sel = 1'b1;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OP_STR) || (opcode == OP_PUSH);
        sp_we    = dmem_ready && (opcode == OP_PUSH);
      end
      S_WB: begin
        reg_we = 1'b1;
        sp_we  = (opcode == OP_POP);
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_src2_sel = 1'b0;
    ext_sel      = 1'b0;
    if ((opcode == 4'h0) || ((opcode >= 4'h2) && (opcode <= 4'h6))) begin
      alu_src2_sel = ir_reg[5];
      ext_sel      = ir_reg[5];
    end else if (is_mem_op) begin
      alu_src2_sel = 1'b1;
      ext_sel      = 1'b1;
    end else if ((opcode == OP_BR) || (opcode == OP_JMP)) begin
      ext_sel = 1'b1;
    end
  end

  assign alu_op    = active ? alu_code : '0;
  assign wd_sel    = active && ((opcode == OP_LDR) || (opcode == OP_POP));
  assign push_ctrl = active && (opcode == OP_PUSH);
  assign pop_ctrl  = active && (opcode == OP_POP);
  assign halted    = (state_reg == S_HALT);
  assign state     = state_reg;
  assign ir        = ir_reg;

endmodule

// File: tb/tb_mc_control_unit.sv
// tb_mc_control_unit: randomized bench for mc_control_unit.
// Each instruction is expanded into its expected cycle sequence from the
// instruction-class rules (wait counts, MUL length, branch condition), and
// every cycle is compared at the falling edge.
module tb_mc_control_unit;

  localparam int INST_W  = 16;
  localparam int ALUOP_W = 4;
  localparam int MUL_C   = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [INST_W-1:0]  imem_rdata = '0;
  logic               imem_ready = 1'b0;
  logic               dmem_ready = 1'b0;
  logic               n = 1'b0, z = 1'b0, p = 1'b0;
  logic               resume = 1'b0;
  logic               imem_req;
  logic [INST_W-1:0]  ir;
  logic               pc_we, pc_sel;
  logic [ALUOP_W-1:0] alu_op;
  logic               alu_src2_sel, ext_sel, wd_sel, reg_we;
  logic               dmem_req, dmem_we, push_ctrl, pop_ctrl, sp_we;
  logic               halted;
  logic [2:0]         state;

  mc_control_unit #(
    .INST_W(INST_W), .ALUOP_W(ALUOP_W), .MUL_CYCLES(MUL_C)
  ) dut (
    .clk(clk), .rst(rst), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .n(n), .z(z), .p(p), .resume(resume),
    .imem_req(imem_req), .ir(ir), .pc_we(pc_we), .pc_sel(pc_sel),
    .alu_op(alu_op), .alu_src2_sel(alu_src2_sel), .ext_sel(ext_sel),
    .wd_sel(wd_sel), .reg_we(reg_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .push_ctrl(push_ctrl), .pop_ctrl(pop_ctrl), .sp_we(sp_we),
    .halted(halted), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] m_ir = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ALU code of an instruction class
  function automatic logic [3:0] exp_alu(input logic [15:0] i);
    logic [3:0] op;
    op = i[15:12];
    if (op <= 4'h8) return op;
    case (op)
      4'h9:    return 4'b0000;
      4'hB:    return 4'b1011;
      4'hC:    return 4'b1100;
      4'hE:    return 4'b0010;
      default: return 4'b1111;
    endcase
  endfunction

  // {alu_src2_sel, ext_sel, wd_sel, push_ctrl, pop_ctrl} for an instruction
  function automatic logic [4:0] exp_sel(input logic [15:0] i);
    logic [3:0] op;
    logic src2, ext;
    op = i[15:12];
    src2 = 1'b0;
    ext  = 1'b0;
    if (op == 4'h0 || (op >= 4'h2 && op <= 4'h6)) begin
      src2 = i[5];
      ext  = i[5];
    end else if (op >= 4'h9 && op <= 4'hC) begin
      src2 = 1'b1;
      ext  = 1'b1;
    end else if (op == 4'hD || op == 4'hE) begin
      ext = 1'b1;
    end
    return {src2, ext, (op == 4'h9 || op == 4'hC), (op == 4'hB), (op == 4'hC)};
  endfunction

  task automatic noise();
    imem_ready = 1'($urandom);
    dmem_ready = 1'($urandom);
    imem_rdata = 16'($urandom);
    resume     = 1'($urandom);
    n = 1'($urandom);
    z = 1'($urandom);
    p = 1'($urandom);
  endtask

  // sb = {imem_req, pc_we, pc_sel, reg_we, dmem_req, dmem_we, sp_we, halted}
  task automatic step(input logic [2:0] st, input logic [7:0] sb);
    @(negedge clk);
    check("state", 32'(state), 32'(st));
    check("strobes", 32'({imem_req, pc_we, pc_sel, reg_we, dmem_req, dmem_we, sp_we, halted}), 32'(sb));
    check("ir", 32'(ir), 32'(m_ir));
    if (st == 3'd2 || st == 3'd3 || st == 3'd4) begin
      check("alu_op", 32'(alu_op), 32'(exp_alu(m_ir)));
      check("sel", 32'({alu_src2_sel, ext_sel, wd_sel, push_ctrl, pop_ctrl}), 32'(exp_sel(m_ir)));
    end else begin
      check("ctl_idle", 32'({alu_op, wd_sel, push_ctrl, pop_ctrl}), 32'h0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input logic [15:0] instr, input int iw);
    for (int k = 0; k < iw; k++) begin
      noise(); imem_ready = 1'b0;
      step(3'd0, 8'b1000_0000);
    end
    noise(); imem_ready = 1'b1; imem_rdata = instr;
    step(3'd0, 8'b1100_0000);
    m_ir = instr;
    noise();
    step(3'd1, 8'b0000_0000);
  endtask

  task automatic run_instr(input logic [15:0] instr, input int iw, input int dw, input int hw,
                           input logic fn, input logic fz, input logic fp);
    logic [3:0] op;
    logic take, wr;
    op = instr[15:12];
    fetch_decode(instr, iw);
    if (op == 4'hF) begin
      for (int k = 0; k < hw; k++) begin
        noise(); resume = 1'b0;
        step(3'd5, 8'b0000_0001);
      end
      noise(); resume = 1'b1;
      step(3'd5, 8'b0000_0001);
    end else begin
      take = (fn & instr[11]) | (fz & instr[10]) | (fp & instr[9]);
      if (op == 4'hD) begin
        noise(); n = fn; z = fz; p = fp;
        step(3'd2, take ? 8'b0110_0000 : 8'b0000_0000);
      end else if (op == 4'hE) begin
        noise();
        step(3'd2, 8'b0110_0000);
      end else if (op >= 4'h9) begin
        noise();
        step(3'd2, 8'b0000_0000);
        wr = (op == 4'hA) || (op == 4'hB);
        for (int k = 0; k < dw; k++) begin
          noise(); dmem_ready = 1'b0;
          step(3'd3, {4'b0000, 1'b1, wr, 2'b00});
        end
        noise(); dmem_ready = 1'b1;
        step(3'd3, {4'b0000, 1'b1, wr, (op == 4'hB), 1'b0});
        if (op == 4'h9 || op == 4'hC) begin
          noise();
          step(3'd4, {3'b000, 1'b1, 2'b00, (op == 4'hC), 1'b0});
        end
      end else begin
        for (int k = 0; k < ((op == 4'h6) ? MUL_C : 1); k++) begin
          noise();
          step(3'd2, 8'b0000_0000);
        end
        noise();
        step(3'd4, 8'b0001_0000);
      end
    end
    $display("instr %04h op %0h iw %0d dw %0d hw %0d done at %0t", instr, op, iw, dw, hw, $time);
  endtask

  // Reset arrives in the current cycle; afterwards the instruction must be gone.
  task automatic reset_cycle(input logic [2:0] st);
    noise(); dmem_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("abort_state", 32'(state), 32'(st));
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_ir = '0;
    for (int k = 0; k < 3; k++) begin
      noise(); imem_ready = 1'b0;
      step(3'd0, 8'b1000_0000);
    end
  endtask

  task automatic abort_push();
    fetch_decode(16'hB000 | 16'($urandom_range(0, 4095)), 0);
    noise();
    step(3'd2, 8'b0000_0000);
    noise(); dmem_ready = 1'b0;
    step(3'd3, 8'b0000_1100);
    reset_cycle(3'd3);
    $display("instr push aborted by reset at %0t", $time);
  endtask

  task automatic abort_mul();
    fetch_decode(16'h6000 | 16'($urandom_range(0, 4095)), 1);
    noise();
    step(3'd2, 8'b0000_0000);
    reset_cycle(3'd2);
    $display("instr mul aborted by reset at %0t", $time);
  endtask

  initial begin
    noise();
    rst = 1'b1;
    @(posedge clk);
    #1;
    noise();
    step(3'd0, 8'b0000_0000);   // reset held: everything quiet, ir cleared
    rst = 1'b0;

    run_instr(16'h0025, 1, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(16'h0025, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(16'h6000, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(16'h9000, 0, 3, 0, 1'b0, 1'b0, 1'b0);
    run_instr(16'hD800, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    run_instr(16'hD800, 0, 0, 0, 1'b0, 1'b1, 1'b0);
    run_instr(16'hF000, 0, 0, 9, 1'b0, 1'b0, 1'b0);
    run_instr(16'hC000, 2, 1, 0, 1'b0, 1'b0, 1'b0);
    run_instr(16'hB000, 0, 2, 0, 1'b0, 1'b0, 1'b0);
    run_instr(16'hA020, 1, 0, 0, 1'b0, 1'b0, 1'b0);
    run_instr(16'hE000, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    abort_push();
    abort_mul();

    for (int t = 0; t < 80; t++) begin
      run_instr(16'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 4), 1'($urandom), 1'($urandom), 1'($urandom));
      if (t % 20 == 10) begin
        if (t % 40 == 10) abort_push();
        else abort_mul();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 Parameter INST_W, default 16, instruction width; opcode is ir[INST_W-1:INST_W-4], BR flags ir[INST_W-5:INST_W-7], imm select ir[5].
REQ-002 Parameter ALUOP_W, default 4, ALU operation code width.
REQ-003 Parameter MUL_CYCLES, default 4, EXEC cycles for MUL (1..15).
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 imem_rdata  input  INST_W  instruction from instruction memory.
REQ-007 imem_ready  input  1  imem_rdata valid this cycle.
REQ-008 dmem_ready  input  1  data memory access complete this cycle.
REQ-009 n, z, p  input  1 each  condition flags.
REQ-010 resume  input  1  leave HALT.
REQ-011 imem_req  output  1  instruction fetch request.
REQ-012 ir  output  INST_W  latched instruction register.
REQ-013 pc_we, pc_sel  output  1 each  PC write strobe; 0 = PC+1, 1 = branch/jump target.
REQ-014 alu_op  output  ALUOP_W;  alu_src2_sel, ext_sel, wd_sel, reg_we  output  1 each.
REQ-015 dmem_req, dmem_we, push_ctrl, pop_ctrl, sp_we  output  1 each  data memory / stack control.
REQ-016 halted  output  1;  state  output  3  current FSM state (debug).

Function
REQ-017 FSM states SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6-7 SHALL return to FETCH next cycle.
REQ-018 FETCH: imem_req=1; on imem_ready, ir<=imem_rdata, pc_we=1 with pc_sel=0 in that cycle, next DECODE; otherwise stay FETCH.
REQ-019 DECODE: one cycle, no strobes; opcode F -> HALT, else -> EXEC.
REQ-020 EXEC, opcodes 0-5,7,8: one cycle, -> WB.
REQ-021 EXEC, MUL (6): mul counter counts 0..MUL_CYCLES-1, stays in EXEC, -> WB after MUL_CYCLES cycles; counter clears on exit.
REQ-022 EXEC, BR (D): pc_we=pc_sel=1 iff (n&ir[11])|(z&ir[10])|(p&ir[9]) sampled this cycle; -> FETCH.
REQ-023 EXEC, JMP (E): pc_we=pc_sel=1 unconditionally; -> FETCH.
REQ-024 EXEC, opcodes 9-C: -> MEM.
REQ-025 MEM: dmem_req=1 held until dmem_ready; dmem_we=1 for STR/PUSH; on dmem_ready STR -> FETCH, PUSH -> FETCH with sp_we=1 that cycle, LDR/POP -> WB.
REQ-026 WB: reg_we=1 for exactly one cycle, sp_we=1 additionally for POP; -> FETCH.
REQ-027 HALT: halted=1, imem_req=0; resume=1 -> FETCH next cycle.
REQ-028 alu_op SHALL equal opcode for 0-8, 0000 for 9, 1111 for A/D/F, 1011 for B, 1100 for C, 0010 for E; driven in EXEC/MEM/WB, 0 elsewhere.
REQ-029 alu_src2_sel=ext_sel=ir[5] for opcodes 0,2-6; alu_src2_sel=ext_sel=1 for 9-C; ext_sel=1 for D/E; else 0.
REQ-030 wd_sel=1 for LDR/POP; push_ctrl=1 for PUSH, pop_ctrl=1 for POP, during EXEC/MEM/WB only.
REQ-031 All outputs SHALL be registered-state functions (Moore on state+ir+counter), except pc_we/sp_we/ir load, which also depend on imem_ready/dmem_ready/flags in the stated cycles.
REQ-032 reg_we and dmem_we SHALL never be high in the same cycle; exactly one reg_we pulse per register-writing instruction.

Reset
REQ-033 rst=1 at a clock edge SHALL force state=FETCH, ir=0, mul counter=0; all outputs 0 except imem_req=1 in the cycle after reset is released.
REQ-034 rst during MEM wait or MUL SHALL abort the instruction: no reg_we, sp_we or pc_we pulse afterwards.

Verification
REQ-035 ADD imm (0x0025), imem_ready=1 at once -> FETCH,DECODE,EXEC,WB; one reg_we in WB; alu_src2_sel=1, alu_op=0000; 4 cycles total.
REQ-036 MUL (0x6000), MUL_CYCLES=4 -> EXEC held 4 cycles, alu_op=0110, reg_we in cycle 7 after fetch start.
REQ-037 LDR with dmem_ready delayed 3 cycles -> dmem_req high 4 cycles, dmem_we=0, then WB with wd_sel=1, reg_we=1.
REQ-038 BR 0xD800 with n=1 -> pc_we=pc_sel=1 in EXEC; with n=0,z=1 -> no pc_we in EXEC.
REQ-039 HALT 0xF000 -> halted=1, imem_req=0 for 10 cycles; resume pulse -> FETCH next cycle, halted=0.
REQ-040 PUSH with rst asserted during MEM wait -> next cycle state=FETCH, dmem_req=0, no sp_we observed.
